line_writeback: RTL and testbench
=================================

# line_writeback

Writeback reader for the cache line register array. On a request for a set index, it reads that line's tag, valid, dirty and data fields and tests whether the line is valid and dirty. A valid, dirty line is streamed to memory as an address phase followed by data beats over valid/ready handshakes, and the line's dirty bit is then cleared through the array's write-enable path. The block sits between the cache controller (eviction/flush requests) and the memory write port.

## Interface
- TAG_BITS, 51, tag field width
- DATA_WIDTH, 1024, line data width in bits
- INDEX_BITS, 6, set index width
- BEAT_WIDTH, 64, memory write beat width; multiple of 8; DATA_WIDTH % BEAT_WIDTH == 0
- Derived: NBEATS = DATA_WIDTH/BEAT_WIDTH; OFF_BITS = $clog2(DATA_WIDTH/8); ADDR_BITS = TAG_BITS+INDEX_BITS+OFF_BITS

Ports:
- clk_i  in  1  clock
- arst_i  in  1  reset; asynchronous, active-high
- req_valid_i / req_ready_o  in/out  1  writeback request handshake
- req_index_i  in  INDEX_BITS  set index to write back
- rd_index_o  out  INDEX_BITS  read select to line array
- line_tag_i / line_val_i / line_dirty_i  in  TAG_BITS/1/1  line fields at rd_index_o
- line_data_i  in  DATA_WIDTH  line data at rd_index_o
- aw_valid_o / aw_ready_i  out/in  1  address handshake
- aw_addr_o  out  ADDR_BITS  {tag, index, OFF_BITS'0}
- w_valid_o / w_ready_i  out/in  1  data beat handshake
- w_data_o  out  BEAT_WIDTH  beat data
- w_strb_o  out  BEAT_WIDTH/8  byte strobes; all ones
- w_last_o  out  1  final beat
- clr_index_o  out  INDEX_BITS  index for dirty/valid clear
- dirty_clr_o  out  1  one-cycle pulse; drive dirty_en with dirty_i=0 at clr_index_o
- val_clr_o  out  1  valid-clear pulse (see Configuration)
- done_o  out  1  one-cycle completion pulse
- done_wrote_o  out  1  qualifies done_o: 1 = line was written back

## Operation
- FSM states: IDLE, ADDR, DATA, FIN.
- IDLE:
  - req_ready_o=1; rd_index_o=req_index_i (combinational).
  - On req_valid_i&&req_ready_o: capture index, tag, data and wrote = line_val_i&&line_dirty_i.
  - Go to ADDR if wrote=1, else FIN.
- In all other states rd_index_o holds the captured index.
- ADDR: aw_valid_o=1 with aw_addr_o stable until aw_ready_i; on handshake go to DATA with beat counter = 0.
- DATA:
  - w_valid_o=1; w_data_o = snapshot[cnt*BEAT_WIDTH +: BEAT_WIDTH] (beat 0 = LSBs).
  - w_last_o = (cnt==NBEATS-1).
  - On w_ready_i, increment cnt; on the handshake with w_last_o=1 go to FIN.
- FIN:
  - done_o=1; done_wrote_o=wrote; dirty_clr_o=wrote; clr_index_o=captured index.
  - Next state: IDLE.
- Data comes from the snapshot, so array writes after acceptance do not affect the beats.
- Invalid lines and clean valid lines produce no aw or w traffic and no clear.

## Timing
- Reset values: FSM=IDLE, cnt=0, snapshot=0.
  - req_ready_o=1.
  - aw_valid_o, w_valid_o, w_last_o, dirty_clr_o, val_clr_o, done_o, done_wrote_o all 0.
  - aw_addr_o, w_data_o, clr_index_o all 0.
- Clean line: accepted at edge 0; done_o high in cycle 1; req_ready_o=1 again in cycle 2.
- Dirty line, sinks always ready:
  - ADDR in cycle 1; beats in cycles 2..NBEATS+1; FIN in cycle NBEATS+2.
  - Back-to-back requests: minimum period NBEATS+3 cycles.
- Backpressure: while valid is high and ready is low, all aw_* and w_* outputs hold stable. Valid never drops without a handshake.
- aw_ready_i or w_ready_i high in a cycle where the matching valid is low has no effect.
- Reset asserted mid-transaction:
  - Immediate return to IDLE with all outputs at reset values.
  - No clear pulse, no done_o; the partial burst is abandoned.
  - The next request restarts at beat 0.
- req_valid_i outside IDLE is ignored (req_ready_o=0).

## Configuration
- LINE_WB_INVALIDATE_EN defined: in FIN with wrote=1, val_clr_o pulses together with dirty_clr_o (flush-and-invalidate). In FIN with wrote=0 and line_val_i captured as 1 (clean valid line), val_clr_o also pulses.
- Not defined: val_clr_o is tied to 0; only the dirty bit is cleared.

## Test plan
- Reset: assert arst_i asynchronously between edges -> all outputs at reset values; req_ready_o=1.
- Clean line (val=1, dirty=0), idx=5 -> done_o=1, done_wrote_o=0 in cycle 1; no aw_valid_o, no w_valid_o, dirty_clr_o=0.
- Dirty line, idx=3, tag=0x1234, data byte i = i, defaults, always-ready sinks:
  - aw_addr_o = {0x1234, 6'd3, 7'd0} in cycle 1.
  - 16 beats; beat0 = 0x0706050403020100; w_last_o only on beat 15.
  - FIN in cycle 18 with dirty_clr_o=1, clr_index_o=3.
- Backpressure: aw_ready_i low for 3 cycles, then w_ready_i alternating 0/1 -> outputs stable while stalled; exactly 16 beat handshakes in order; single done_o.
- Snapshot isolation and mid-op reset:
  - Change line_data_i during DATA -> beats unchanged.
  - Assert arst_i during beat 5 -> no dirty_clr_o and no done_o.
  - Re-request -> beat 0 is re-sent first.
- Build with LINE_WB_INVALIDATE_EN -> val_clr_o pulses in the same cycle as dirty_clr_o. Build without -> val_clr_o stays 0 for all scenarios.

Source files
------------

// File: rtl/line_writeback.sv
// Writeback reader for the cache line array: snapshots a requested line and streams it to memory as
// one address phase plus NBEATS data beats, then pulses a dirty-bit clear. Optional macro: LINE_WB_INVALIDATE_EN.
module line_writeback #(
    parameter int TAG_BITS   = 51,
    parameter int DATA_WIDTH = 1024,
    parameter int INDEX_BITS = 6,
    parameter int BEAT_WIDTH = 64,
    localparam int NBEATS    = DATA_WIDTH / BEAT_WIDTH,
    localparam int OFF_BITS  = $clog2(DATA_WIDTH / 8),
    localparam int ADDR_BITS = TAG_BITS + INDEX_BITS + OFF_BITS
) (
    input  logic                    clk_i,
    input  logic                    arst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [INDEX_BITS-1:0]   req_index_i,
    output logic [INDEX_BITS-1:0]   rd_index_o,
    input  logic [TAG_BITS-1:0]     line_tag_i,
    input  logic                    line_val_i,
    input  logic                    line_dirty_i,
    input  logic [DATA_WIDTH-1:0]   line_data_i,
    output logic                    aw_valid_o,
    input  logic                    aw_ready_i,
    output logic [ADDR_BITS-1:0]    aw_addr_o,
    output logic                    w_valid_o,
    input  logic                    w_ready_i,
    output logic [BEAT_WIDTH-1:0]   w_data_o,
    output logic [BEAT_WIDTH/8-1:0] w_strb_o,
    output logic                    w_last_o,
    output logic [INDEX_BITS-1:0]   clr_index_o,
    output logic                    dirty_clr_o,
    output logic                    val_clr_o,
    output logic                    done_o,
    output logic                    done_wrote_o
);

    localparam int CNT_BITS = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, FIN} state_t;

    state_t                  state_reg, state_next;
    logic [CNT_BITS-1:0]     cnt_reg, cnt_next;
    logic [INDEX_BITS-1:0]   idx_reg;
    logic [TAG_BITS-1:0]     tag_reg;
    logic [DATA_WIDTH-1:0]   data_reg;
    logic                    wrote_reg;
    logic                    accept;
    logic                    last_beat;
    logic [BEAT_WIDTH-1:0]   beats [NBEATS];

    assign accept    = (state_reg == IDLE) && req_valid_i;
    assign last_beat = (cnt_reg == CNT_BITS'(NBEATS - 1));

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Snapshot of the line taken at acceptance; later array writes cannot disturb the burst.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            idx_reg   <= '0;
            tag_reg   <= '0;
            data_reg  <= '0;
            wrote_reg <= 1'b0;
        end else if (accept) begin
            idx_reg   <= req_index_i;
            tag_reg   <= line_tag_i;
            data_reg  <= line_data_i;
            wrote_reg <= line_val_i && line_dirty_i;
        end
    end

    generate
        for (genvar gi = 0; gi < NBEATS; gi++) begin : g_beat
            assign beats[gi] = data_reg[gi*BEAT_WIDTH +: BEAT_WIDTH];
        end
    endgenerate

    assign aw_addr_o   = {tag_reg, idx_reg, {OFF_BITS{1'b0}}};
    assign w_data_o    = beats[cnt_reg];
    assign w_strb_o    = '1;
    assign clr_index_o = idx_reg;

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        req_ready_o  = 1'b0;
        rd_index_o   = idx_reg;
        aw_valid_o   = 1'b0;
        w_valid_o    = 1'b0;
        w_last_o     = 1'b0;
        dirty_clr_o  = 1'b0;
        done_o       = 1'b0;
        done_wrote_o = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready_o = 1'b1;
                rd_index_o  = req_index_i;
                if (req_valid_i) begin
                    state_next = (line_val_i && line_dirty_i) ? ADDR : FIN;
                end
            end
            ADDR: begin
                aw_valid_o = 1'b1;
                if (aw_ready_i) begin
                    state_next = DATA;
                    cnt_next   = '0;
                end
            end
            DATA: begin
                w_valid_o = 1'b1;
                w_last_o  = last_beat;
                if (w_ready_i) begin
                    if (last_beat) begin
                        state_next = FIN;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            FIN: begin
                done_o       = 1'b1;
                done_wrote_o = wrote_reg;
                dirty_clr_o  = wrote_reg;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef LINE_WB_INVALIDATE_EN
    // Captured valid bit: a written line is always valid, so this covers both invalidate cases.
    logic val_reg;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            val_reg <= 1'b0;
        end else if (accept) begin
            val_reg <= line_val_i;
        end
    end

    assign val_clr_o = (state_reg == FIN) && val_reg;
`else
    assign val_clr_o = 1'b0;
`endif

endmodule

// File: tb/tb_line_writeback.sv
// Bench for line_writeback: table-driven directed rows, hand sequences for stall/snapshot/reset,
// and randomized requests checked against a line-array reference model.
module tb_line_writeback;

    localparam int SETS = 64;

    logic          clk = 1'b0;
    logic          arst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [5:0]    req_index = '0;
    logic [5:0]    rd_index;
    logic [50:0]   line_tag;
    logic          line_val, line_dirty;
    logic [1023:0] line_data;
    logic          aw_valid, aw_ready = 1'b0;
    logic [63:0]   aw_addr;
    logic          w_valid, w_ready = 1'b0;
    logic [63:0]   w_data;
    logic [7:0]    w_strb;
    logic          w_last;
    logic [5:0]    clr_index;
    logic          dirty_clr, val_clr, done, done_wrote;

    logic [50:0]   tag_mem  [SETS];
    logic          val_mem  [SETS];
    logic          dirty_mem[SETS];
    logic [1023:0] data_mem [SETS];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign line_tag   = tag_mem[rd_index];
    assign line_val   = val_mem[rd_index];
    assign line_dirty = dirty_mem[rd_index];
    assign line_data  = data_mem[rd_index];

    line_writeback dut (
        .clk_i(clk), .arst_i(arst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_index_i(req_index),
        .rd_index_o(rd_index),
        .line_tag_i(line_tag), .line_val_i(line_val), .line_dirty_i(line_dirty), .line_data_i(line_data),
        .aw_valid_o(aw_valid), .aw_ready_i(aw_ready), .aw_addr_o(aw_addr),
        .w_valid_o(w_valid), .w_ready_i(w_ready), .w_data_o(w_data), .w_strb_o(w_strb), .w_last_o(w_last),
        .clr_index_o(clr_index), .dirty_clr_o(dirty_clr), .val_clr_o(val_clr),
        .done_o(done), .done_wrote_o(done_wrote)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_valids"}, {aw_valid, w_valid, w_last}, 0);
        check({tag, "_pulses"}, {dirty_clr, val_clr, done, done_wrote}, 0);
        check({tag, "_aw_addr"}, aw_addr, 0);
        check({tag, "_w_data"}, w_data, 0);
        check({tag, "_clr_index"}, clr_index, 0);
    endtask

    // One request, observed cycle by cycle on the falling edge. md: 0 always-ready sinks,
    // 1 random readies plus ignored requests while busy, 2 aw stalled 3 cycles then w alternating.
    task automatic do_req(input int idx, input int md, input bit corrupt, input int reset_beat,
                          output bit wrote_o, output int lat_o,
                          output logic [63:0] beat0_o, output logic [63:0] addr_o);
        logic [5:0]    ix;
        logic [63:0]   exp_addr, prev_addr, prev_wdata, exp_beat;
        logic [1023:0] exp_data;
        bit            exp_wrote, exp_vclr, prev_aw_stall, prev_w_stall, prev_wlast;
        bit            finished, aborted, corrupted, w_tog;
        int            beats_seen, aw_seen, aw_wait;

        ix        = idx[5:0];
        exp_wrote = val_mem[ix] && dirty_mem[ix];
`ifdef LINE_WB_INVALIDATE_EN
        exp_vclr  = exp_wrote || val_mem[ix];
`else
        exp_vclr  = 1'b0;
`endif
        exp_addr  = {tag_mem[ix], ix, 7'b0};
        exp_data  = data_mem[ix];
        prev_aw_stall = 0; prev_w_stall = 0; prev_addr = '0; prev_wdata = '0; prev_wlast = 0;
        finished = 0; aborted = 0; corrupted = 0; w_tog = 0;
        beats_seen = 0; aw_seen = 0; aw_wait = 0;
        wrote_o = 0; lat_o = -1; beat0_o = '0; addr_o = '0;

        req_valid = 1'b1;
        req_index = ix;
        check("req_ready_idle", req_ready, 1);
        @(posedge clk);
        for (int c = 1; c <= 200 && !finished; c++) begin
            @(negedge clk);
            req_valid = (md == 1 && !done) ? 1'($urandom_range(0, 1)) : 1'b0;
            req_index = 6'($urandom);
            if (c == 1) check("req_ready_busy", req_ready, 0);
            case (md)
                0: begin aw_ready = 1'b1; w_ready = 1'b1; end
                1: begin aw_ready = 1'($urandom_range(0, 1)); w_ready = 1'($urandom_range(0, 1)); end
                default: begin
                    aw_ready = (aw_wait >= 3);
                    if (aw_valid && !aw_ready) aw_wait++;
                    w_ready = w_tog;
                    if (w_valid) w_tog = ~w_tog;
                end
            endcase
            if (prev_aw_stall) begin
                check("aw_hold_valid", aw_valid, 1);
                check("aw_hold_addr", aw_addr, prev_addr);
            end
            if (prev_w_stall) begin
                check("w_hold_valid", w_valid, 1);
                check("w_hold_data", w_data, prev_wdata);
                check("w_hold_last", w_last, prev_wlast);
            end
            if (reset_beat >= 0 && w_valid && beats_seen == reset_beat) begin
                req_valid = 1'b0;
                #2 arst = 1'b1;
                #1 check_reset_outputs("midreset");
                @(negedge clk);
                check("midreset_no_done", {done, dirty_clr, val_clr}, 0);
                arst = 1'b0;
                check("midreset_dirty_kept", dirty_mem[ix], 1);
                aborted  = 1;
                finished = 1;
            end else begin
                if (aw_valid && aw_ready) begin
                    aw_seen++;
                    addr_o = aw_addr;
                    check("aw_addr", aw_addr, exp_addr);
                end
                if (w_valid && w_ready) begin
                    if (beats_seen < 16) begin
                        exp_beat = exp_data[beats_seen*64 +: 64];
                        check("w_data", w_data, exp_beat);
                        check("w_last", w_last, (beats_seen == 15) ? 1 : 0);
                        check("w_strb", w_strb, 8'hff);
                    end else begin
                        check("beat_overrun", beats_seen, 15);
                    end
                    if (beats_seen == 0) beat0_o = w_data;
                    beats_seen++;
                end
                if (corrupt && !corrupted && beats_seen > 0) begin
                    data_mem[ix] = ~exp_data;
                    corrupted = 1;
                end
                prev_aw_stall = aw_valid && !aw_ready;
                prev_addr     = aw_addr;
                prev_w_stall  = w_valid && !w_ready;
                prev_wdata    = w_data;
                prev_wlast    = w_last;
                if (done) begin
                    check("done_wrote", done_wrote, exp_wrote);
                    check("dirty_clr", dirty_clr, exp_wrote);
                    check("val_clr", val_clr, exp_vclr);
                    check("clr_index", clr_index, ix);
                    check("aw_count", aw_seen, exp_wrote ? 1 : 0);
                    check("beat_count", beats_seen, exp_wrote ? 16 : 0);
                    wrote_o  = done_wrote;
                    lat_o    = c;
                    finished = 1;
                end else begin
                    check("stray_clr", {dirty_clr, val_clr}, 0);
                end
                if (dirty_clr) dirty_mem[clr_index] = 1'b0;
                if (val_clr)   val_mem[clr_index]   = 1'b0;
            end
        end
        if (!finished) check("timeout_done", 0, 1);
        if (!aborted) begin
            @(negedge clk);
            check("req_ready_after", req_ready, 1);
            check("done_single", done, 0);
        end
    endtask

    typedef struct {
        int          idx;
        bit          val;
        bit          dirty;
        logic [50:0] tag;
        int          md;
        bit          exp_wrote;
        int          exp_lat;
    } vec_t;

    vec_t          vecs[6];
    bit            wrote;
    int            lat;
    logic [63:0]   beat0, addr;
    logic [1023:0] d;
    logic [5:0]    ri;

    initial begin
        vecs[0] = '{idx: 5,  val: 1, dirty: 0, tag: 51'h0abc,    md: 0, exp_wrote: 0, exp_lat: 1};
        vecs[1] = '{idx: 7,  val: 0, dirty: 1, tag: 51'h0777,    md: 0, exp_wrote: 0, exp_lat: 1};
        vecs[2] = '{idx: 9,  val: 0, dirty: 0, tag: 51'h0999,    md: 0, exp_wrote: 0, exp_lat: 1};
        vecs[3] = '{idx: 3,  val: 1, dirty: 1, tag: 51'h1234,    md: 0, exp_wrote: 1, exp_lat: 18};
        vecs[4] = '{idx: 63, val: 1, dirty: 1, tag: {51{1'b1}},  md: 0, exp_wrote: 1, exp_lat: 18};
        vecs[5] = '{idx: 0,  val: 1, dirty: 1, tag: 51'h5a5a5,   md: 2, exp_wrote: 1, exp_lat: -1};

        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < 32; w++) d[w*32 +: 32] = $urandom;
            data_mem[s]  = d;
            tag_mem[s]   = {19'($urandom), 32'($urandom)};
            val_mem[s]   = 1'b0;
            dirty_mem[s] = 1'b0;
        end

        // Asynchronous reset between clock edges
        #3 arst = 1'b1;
        #1 check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        arst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            val_mem[vecs[v].idx]   = vecs[v].val;
            dirty_mem[vecs[v].idx] = vecs[v].dirty;
            tag_mem[vecs[v].idx]   = vecs[v].tag;
            if (vecs[v].idx == 3) begin
                for (int b = 0; b < 128; b++) d[b*8 +: 8] = b[7:0];
                data_mem[3] = d;
            end
            do_req(vecs[v].idx, vecs[v].md, 0, -1, wrote, lat, beat0, addr);
            check("vec_wrote", wrote, vecs[v].exp_wrote);
            if (vecs[v].exp_lat > 0) check("vec_latency", lat, vecs[v].exp_lat);
            if (vecs[v].idx == 3) begin
                check("idx3_beat0", beat0, 64'h0706050403020100);
                check("idx3_aw_addr", addr, {51'h1234, 6'd3, 7'd0});
            end
            $display("vec %0d idx=%0d wrote=%0d latency=%0d", v, vecs[v].idx, wrote, lat);
        end

        // Back-to-back dirty line, then snapshot isolation while the array changes mid-burst
        val_mem[10] = 1'b1; dirty_mem[10] = 1'b1;
        do_req(10, 0, 1, -1, wrote, lat, beat0, addr);
        check("snapshot_latency", lat, 18);
        $display("snapshot idx=10 wrote=%0d latency=%0d", wrote, lat);

        // Reset during beat 5, then the retry must restart from beat 0
        val_mem[12] = 1'b1; dirty_mem[12] = 1'b1;
        do_req(12, 0, 0, 5, wrote, lat, beat0, addr);
        $display("midreset idx=12 aborted");
        d = data_mem[12];
        do_req(12, 0, 0, -1, wrote, lat, beat0, addr);
        check("retry_beat0", beat0, d[63:0]);
        check("retry_wrote", wrote, 1);
        $display("retry idx=12 wrote=%0d latency=%0d", wrote, lat);

        for (int n = 0; n < 25; n++) begin
            ri = 6'($urandom);
            for (int w = 0; w < 32; w++) d[w*32 +: 32] = $urandom;
            data_mem[ri]  = d;
            tag_mem[ri]   = {19'($urandom), 32'($urandom)};
            val_mem[ri]   = 1'($urandom_range(0, 1));
            dirty_mem[ri] = 1'($urandom_range(0, 1));
            do_req(int'(ri), 1, 0, -1, wrote, lat, beat0, addr);
            $display("rand %0d idx=%0d wrote=%0d latency=%0d", n, ri, wrote, lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
